morse_shifter: RTL

- Downstream consumer of the rate-divider enable pulse.
- On a Start request it loads the Morse pattern for one of eight letters (A–H) from an internal ROM.
- It shifts the pattern out MSB-first, advancing one bit per Tick, and drives a single LED.
- Sits between the RateDivider (Tick source) and a board LEDR pin. The top-level wrapper maps SW[2:0] to Letter and KEY[1] to Start.

---
 rtl/morse_shifter.sv | 101 ++++++++++
 1 files changed

// File: rtl/morse_shifter.sv
// Morse letter transmitter: loads a pattern for letters A-H from a small ROM on a
// Start edge and shifts it out MSB-first, one bit per Tick, to drive an LED.
module morse_shifter #(
  parameter int PATTERN_WIDTH = 12,
  parameter int LEN_WIDTH     = 4
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       MorseOut,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                   state, state_next;
  logic [PATTERN_WIDTH-1:0] shift_reg, shift_next;
  logic [LEN_WIDTH-1:0]     bit_cnt, cnt_next;
  logic                     start_d;
  logic                     start_pulse;
  logic                     done_next;
  logic [11:0]              rom_bits;
  logic [PATTERN_WIDTH-1:0] rom_pattern;
  logic [LEN_WIDTH-1:0]     rom_len;

  // Patterns are stored left-aligned in 12 bits: 1 = lit, dash = three units lit.
  always_comb begin
    rom_bits = 12'b0;
    rom_len  = '0;
    case (Letter)
      3'd0: begin rom_bits = 12'b1011_1000_0000; rom_len = LEN_WIDTH'(5);  end
      3'd1: begin rom_bits = 12'b1110_1010_1000; rom_len = LEN_WIDTH'(9);  end
      3'd2: begin rom_bits = 12'b1110_1011_1010; rom_len = LEN_WIDTH'(11); end
      3'd3: begin rom_bits = 12'b1110_1010_0000; rom_len = LEN_WIDTH'(7);  end
      3'd4: begin rom_bits = 12'b1000_0000_0000; rom_len = LEN_WIDTH'(1);  end
      3'd5: begin rom_bits = 12'b1010_1110_1000; rom_len = LEN_WIDTH'(9);  end
      3'd6: begin rom_bits = 12'b1110_1110_1000; rom_len = LEN_WIDTH'(9);  end
      default: begin rom_bits = 12'b1010_1010_0000; rom_len = LEN_WIDTH'(7); end
    endcase
  end

  assign rom_pattern = PATTERN_WIDTH'(rom_bits) << (PATTERN_WIDTH - 12);
  assign start_pulse = Start & ~start_d;

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = bit_cnt;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          shift_next = rom_pattern;
          cnt_next   = rom_len;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (Tick) begin
          if (bit_cnt > LEN_WIDTH'(1)) begin
            shift_next = shift_reg << 1;
            cnt_next   = bit_cnt - LEN_WIDTH'(1);
          end else begin
            shift_next = '0;
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The Start delay flop tracks Start in every state so a held Start never retriggers.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      start_d   <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      start_d   <= Start;
      Done      <= done_next;
    end
  end

  assign Busy     = (state == SHIFT);
  assign MorseOut = Busy & shift_reg[PATTERN_WIDTH-1];

endmodule
